// File: rtl/wu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : wu_fetch
//  Purpose  : Work-unit instruction fetch stage. Issues one WU memory line
//             read per cycle from a system-supplied start address, throttled
//             by credits owned by the downstream WU decode buffer. Every read
//             already issued is guaranteed a decode-buffer slot.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                   in   rising-edge clock
//    reset_poweron         in   asynchronous, active-high reset
//    sys__wuf__start       in   pulse: begin fetching at sys__wuf__start_addr
//    sys__wuf__start_addr  in   first line to fetch (sampled with start)
//    wud__wuf__release     in   pulse: decode freed one entry (one credit)
//    wud__wuf__stop        in   pulse: decode saw end of program
//    wuf__wum__read        out  registered read strobe to WU memory
//    wuf__wum__addr        out  registered read address (valid with read)
//    wuf__sys__busy        out  high while fetch is running or stalled
//    wuf__sys__count       out  reads issued since last start (wraps)
//    wuf__sys__credit_err  out  sticky: release arrived with credits full
// ============================================================================
module wu_fetch #(
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_DEPTH  = 1024,
    parameter int CREDITS    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    input  logic                  sys__wuf__start,
    input  logic [ADDR_WIDTH-1:0] sys__wuf__start_addr,
    input  logic                  wud__wuf__release,
    input  logic                  wud__wuf__stop,
    output logic                  wuf__wum__read,
    output logic [ADDR_WIDTH-1:0] wuf__wum__addr,
    output logic                  wuf__sys__busy,
    output logic [CNT_WIDTH-1:0]  wuf__sys__count,
    output logic                  wuf__sys__credit_err
);

    localparam int                    CRED_W       = $clog2(CREDITS + 1);
    localparam logic [CRED_W-1:0]     CREDITS_FULL = CRED_W'(CREDITS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST    = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [CRED_W-1:0]      credits_q,   credits_d;
    logic                   read_q,      read_d;
    logic [ADDR_WIDTH-1:0]  addr_q,      addr_d;
    logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
    logic [CNT_WIDTH-1:0]   count_q,     count_d;
    logic                   busy_q,      busy_d;
    logic                   err_q,       err_d;

    logic                   credit_overflow;
    logic [ADDR_WIDTH-1:0]  base_addr;

    always_comb begin
        credit_overflow = 1'b0;
        credits_d       = credits_q;
        err_d           = err_q;
        state_d         = state_q;
        read_d          = 1'b0;
        base_addr       = next_addr_q;
        addr_d          = addr_q;
        next_addr_d     = next_addr_q;
        count_d         = count_q;
        busy_d          = 1'b0;

        // The read currently on the strobe consumes a credit; a release
        // returns one. A release into a full pool is an error and is dropped.
        credit_overflow = wud__wuf__release && (credits_q == CREDITS_FULL) && !read_q;
        if (credit_overflow) begin
            credits_d = credits_q;
        end else begin
            credits_d = credits_q - CRED_W'(read_q) + CRED_W'(wud__wuf__release);
        end
        err_d = err_q | credit_overflow;

        // Start has priority over stop so a coincident pair restarts fetch.
        if (sys__wuf__start) begin
            state_d = (credits_d == '0) ? ST_STALL : ST_RUN;
        end else if (state_q != ST_IDLE) begin
            if (wud__wuf__stop) begin
                state_d = ST_IDLE;
            end else begin
                state_d = (credits_d == '0) ? ST_STALL : ST_RUN;
            end
        end

        read_d = (state_d == ST_RUN) && (credits_d != '0);
        busy_d = (state_d != ST_IDLE);

        // next_addr_q holds the line the next read will use, so a start that
        // lands on an empty credit pool still remembers its start address.
        base_addr = sys__wuf__start ? sys__wuf__start_addr : next_addr_q;
        if (read_d) begin
            addr_d      = base_addr;
            next_addr_d = (base_addr == ADDR_LAST) ? '0 : base_addr + 1'b1;
        end else begin
            next_addr_d = base_addr;
        end

        // The count includes the read being placed on the strobe this edge.
        count_d = (sys__wuf__start ? '0 : count_q) + CNT_WIDTH'(read_d);
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_q     <= ST_IDLE;
            credits_q   <= CREDITS_FULL;
            read_q      <= 1'b0;
            addr_q      <= '0;
            next_addr_q <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            credits_q   <= credits_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign wuf__wum__read       = read_q;
    assign wuf__wum__addr       = addr_q;
    assign wuf__sys__busy       = busy_q;
    assign wuf__sys__count      = count_q;
    assign wuf__sys__credit_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wu_fetch
//  Purpose  : Self-checking bench for wu_fetch: directed scenarios plus a
//             randomized run compared against a credit/queue-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wu_fetch;

    localparam int CREDITS = 4;
    localparam int DEPTH   = 1024;

    logic       clk = 1'b0;
    logic       reset_poweron = 1'b1;
    logic       sys__wuf__start = 1'b0;
    logic [9:0] sys__wuf__start_addr = '0;
    logic       wud__wuf__release = 1'b0;
    logic       wud__wuf__stop = 1'b0;
    logic       wuf__wum__read;
    logic [9:0] wuf__wum__addr;
    logic       wuf__sys__busy;
    logic [15:0] wuf__sys__count;
    logic       wuf__sys__credit_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: fetch is either active or not, owns an integer pool
    // of credits, and walks a line pointer modulo the memory depth.
    bit m_active;
    int m_credits;
    bit m_read;
    int m_addr;
    int m_next;
    int m_count;
    bit m_err;

    wu_fetch #(
        .ADDR_WIDTH (10),
        .MEM_DEPTH  (DEPTH),
        .CREDITS    (CREDITS),
        .CNT_WIDTH  (16)
    ) dut (
        .clk                  (clk),
        .reset_poweron        (reset_poweron),
        .sys__wuf__start      (sys__wuf__start),
        .sys__wuf__start_addr (sys__wuf__start_addr),
        .wud__wuf__release    (wud__wuf__release),
        .wud__wuf__stop       (wud__wuf__stop),
        .wuf__wum__read       (wuf__wum__read),
        .wuf__wum__addr       (wuf__wum__addr),
        .wuf__sys__busy       (wuf__sys__busy),
        .wuf__sys__count      (wuf__sys__count),
        .wuf__sys__credit_err (wuf__sys__credit_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active  = 1'b0;
        m_credits = CREDITS;
        m_read    = 1'b0;
        m_addr    = 0;
        m_next    = 0;
        m_count   = 0;
        m_err     = 1'b0;
    endtask

    task automatic model_step(input bit s, input int sa, input bit rel, input bit stp);
        int  cn;
        bit  issue;
        if (rel && m_credits == CREDITS && !m_read) begin
            cn    = m_credits;
            m_err = 1'b1;
        end else begin
            cn = m_credits - (m_read ? 1 : 0) + (rel ? 1 : 0);
        end
        if (s) begin
            m_active = 1'b1;
            m_next   = sa;
            m_count  = 0;
        end else if (stp) begin
            m_active = 1'b0;
        end
        issue = m_active && (cn > 0);
        if (issue) begin
            m_addr  = m_next;
            m_next  = (m_next + 1) % DEPTH;
            m_count = (m_count + 1) % 65536;
        end
        m_read    = issue;
        m_credits = cn;
    endtask

    // Applies one cycle of inputs, advances the model at the edge, and
    // leaves the bench 1 ns past the edge for sampling.
    task automatic tick(input bit s, input int sa, input bit rel, input bit stp);
        sys__wuf__start      = s;
        sys__wuf__start_addr = 10'(sa);
        wud__wuf__release    = rel;
        wud__wuf__stop       = stp;
        @(posedge clk);
        model_step(s, sa, rel, stp);
        #1;
        sys__wuf__start   = 1'b0;
        wud__wuf__release = 1'b0;
        wud__wuf__stop    = 1'b0;
    endtask

    task automatic do_reset();
        reset_poweron = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_poweron = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({wuf__wum__read, wuf__wum__addr, wuf__sys__busy, wuf__sys__count, wuf__sys__credit_err} !== 29'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: read=%0b addr=%h busy=%0b count=%0d err=%0b required all zero",
                     wuf__wum__read, wuf__wum__addr, wuf__sys__busy, wuf__sys__count, wuf__sys__credit_err);
        end
        do_reset();
        tick(0, 0, 0, 0);
        n_checks++;
        if (wuf__wum__read !== 1'b0 || wuf__sys__busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: read=%0b busy=%0b required 0 0", wuf__wum__read, wuf__sys__busy);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 5; c++) tick(0, 0, 0, 0);
        tick(1, 'h010, 0, 0);
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (wuf__wum__read !== 1'b1 || wuf__wum__addr !== 10'('h010 + k) || wuf__sys__busy !== 1'b1) begin
                n_errors++;
                $display("FAIL stream k=%0d: read=%0b addr=%h busy=%0b required 1 %h 1",
                         k, wuf__wum__read, wuf__wum__addr, wuf__sys__busy, 10'('h010 + k));
            end
            tick(0, 0, k >= 2, 0);
        end
    endtask

    task automatic test_credit_limit();
        do_reset();
        tick(1, 'h020, 0, 0);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (wuf__wum__read !== (k < 4) || wuf__wum__addr !== 10'('h020 + ((k < 4) ? k : 3)) ||
                wuf__sys__busy !== 1'b1) begin
                n_errors++;
                $display("FAIL credit_limit k=%0d: read=%0b addr=%h busy=%0b required %0b %h 1",
                         k, wuf__wum__read, wuf__wum__addr, wuf__sys__busy, (k < 4),
                         10'('h020 + ((k < 4) ? k : 3)));
            end
            tick(0, 0, 0, 0);
        end
        tick(0, 0, 1, 0);
        n_checks++;
        if (wuf__wum__read !== 1'b1 || wuf__wum__addr !== 10'h024) begin
            n_errors++;
            $display("FAIL credit_return: read=%0b addr=%h required 1 024", wuf__wum__read, wuf__wum__addr);
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (wuf__wum__read !== 1'b0 || wuf__wum__addr !== 10'h024 || wuf__sys__busy !== 1'b1) begin
            n_errors++;
            $display("FAIL credit_hold: read=%0b addr=%h busy=%0b required 0 024 1",
                     wuf__wum__read, wuf__wum__addr, wuf__sys__busy);
        end
    endtask

    task automatic test_wrap();
        int exp_addr [4];
        exp_addr = '{'h3FE, 'h3FF, 'h000, 'h001};
        do_reset();
        tick(1, 'h3FE, 1, 0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (wuf__wum__read !== 1'b1 || wuf__wum__addr !== 10'(exp_addr[k]) ||
                wuf__sys__count !== 16'(k + 1)) begin
                n_errors++;
                $display("FAIL wrap k=%0d: read=%0b addr=%h count=%0d required 1 %h %0d",
                         k, wuf__wum__read, wuf__wum__addr, wuf__sys__count, 10'(exp_addr[k]), k + 1);
            end
            tick(0, 0, 1, 0);
        end
    endtask

    task automatic test_stop_credits();
        do_reset();
        tick(1, 'h000, 0, 0);
        for (int k = 0; k < 5; k++) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        n_checks++;
        if (wuf__wum__read !== 1'b0 || wuf__sys__busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stop: read=%0b busy=%0b required 0 0", wuf__wum__read, wuf__sys__busy);
        end
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 1, 0);
            n_checks++;
            if (wuf__sys__credit_err !== 1'b0 || wuf__wum__read !== 1'b0) begin
                n_errors++;
                $display("FAIL release_ok k=%0d: err=%0b read=%0b required 0 0",
                         k, wuf__sys__credit_err, wuf__wum__read);
            end
        end
        tick(0, 0, 1, 0);
        n_checks++;
        if (wuf__sys__credit_err !== 1'b1) begin
            n_errors++;
            $display("FAIL credit_err: err=%0b required 1", wuf__sys__credit_err);
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (wuf__sys__credit_err !== 1'b1) begin
            n_errors++;
            $display("FAIL credit_err_sticky: err=%0b required 1", wuf__sys__credit_err);
        end
    endtask

    task automatic test_start_stop();
        do_reset();
        tick(1, 'h050, 0, 0);
        for (int k = 0; k < 3; k++) tick(0, 0, 1, 0);
        tick(1, 'h100, 1, 1);
        n_checks++;
        if (wuf__wum__read !== 1'b1 || wuf__wum__addr !== 10'h100 ||
            wuf__sys__count !== 16'd1 || wuf__sys__busy !== 1'b1) begin
            n_errors++;
            $display("FAIL start_stop: read=%0b addr=%h count=%0d busy=%0b required 1 100 1 1",
                     wuf__wum__read, wuf__wum__addr, wuf__sys__count, wuf__sys__busy);
        end
    endtask

    task automatic test_async_reset();
        int reads;
        do_reset();
        tick(1, 'h000, 1, 0);
        for (int k = 0; k < 3; k++) tick(0, 0, 1, 0);
        #3;
        reset_poweron = 1'b1;
        #1;
        n_checks++;
        if (wuf__wum__read !== 1'b0 || wuf__wum__addr !== 10'd0 ||
            wuf__sys__count !== 16'd0 || wuf__sys__busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: read=%0b addr=%h count=%0d busy=%0b required 0 000 0 0",
                     wuf__wum__read, wuf__wum__addr, wuf__sys__count, wuf__sys__busy);
        end
        model_reset();
        @(negedge clk);
        reset_poweron = 1'b0;
        tick(1, 'h200, 0, 0);
        reads = 0;
        for (int k = 0; k < 6; k++) begin
            if (wuf__wum__read === 1'b1) reads++;
            tick(0, 0, 0, 0);
        end
        n_checks++;
        if (reads != 4 || wuf__sys__count !== 16'd4) begin
            n_errors++;
            $display("FAIL reset_credits: reads=%0d count=%0d required 4 4", reads, wuf__sys__count);
        end
    endtask

    task automatic test_random();
        bit s, rel, stp;
        int sa;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            s   = ($urandom_range(0, 31) == 0) || (c == 0);
            sa  = $urandom_range(0, DEPTH - 1);
            rel = ($urandom_range(0, 1) == 1);
            stp = ($urandom_range(0, 39) == 0);
            tick(s, sa, rel, stp);
            n_checks++;
            if (wuf__wum__read !== m_read || wuf__wum__addr !== 10'(m_addr) ||
                wuf__sys__busy !== m_active || wuf__sys__count !== 16'(m_count) ||
                wuf__sys__credit_err !== m_err) begin
                n_errors++;
                $display("FAIL random c=%0d: read=%0b addr=%h busy=%0b count=%0d err=%0b required %0b %h %0b %0d %0b",
                         c, wuf__wum__read, wuf__wum__addr, wuf__sys__busy, wuf__sys__count,
                         wuf__sys__credit_err, m_read, 10'(m_addr), m_active, m_count, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_credit_limit();
        test_wrap();
        test_stop_credits();
        test_start_stop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wu_fetch.md
Name: wu_fetch

Overview:
- Work-unit instruction fetch stage for the manager.
- Sits directly upstream of the storage-descriptor/WU instruction memory. It drives the memory's read strobe and address, one WU memory line per cycle, starting from a system-supplied start address.
- Flow control is credit-based against the downstream WU decode buffer. Every read the memory returns two cycles later always has a guaranteed slot.
- Fetch runs until decode signals stop. Fetch does not interpret instruction contents.

Parameters:
ADDR_WIDTH, 10, width of WU memory address (matches manager WU address range)
MEM_DEPTH, 1024, number of WU memory lines; address wraps at MEM_DEPTH-1
CREDITS, 4, decode buffer entries; max outstanding unreleased reads
CNT_WIDTH, 16, width of issued-read counter

Ports:
clk  input  1  single clock, rising edge
reset_poweron  input  1  asynchronous, active-high reset
sys__wuf__start  input  1  single-cycle pulse; begin fetching at sys__wuf__start_addr
sys__wuf__start_addr  input  ADDR_WIDTH  first line to fetch; sampled only with start
wud__wuf__release  input  1  single-cycle pulse; decode freed one buffer entry (returns one credit)
wud__wuf__stop  input  1  single-cycle pulse; decode saw end of program, halt fetch
wuf__wum__read  output  1  read strobe to WU memory, registered
wuf__wum__addr  output  ADDR_WIDTH  read address to WU memory, registered; valid when read=1
wuf__sys__busy  output  1  high while state is RUN or STALL
wuf__sys__count  output  CNT_WIDTH  reads issued since last start, wraps
wuf__sys__credit_err  output  1  sticky; a release arrived with credits already at CREDITS

Behaviour:
- Reset (async, immediate): state=IDLE, wuf__wum__read=0, wuf__wum__addr=0, credits=CREDITS, wuf__sys__count=0, wuf__sys__busy=0, wuf__sys__credit_err=0. All outputs are registered.
- States:
  - IDLE: no reads.
  - RUN: issuing reads.
  - STALL: running, but credits_next==0.
- Credit arithmetic, evaluated every edge: credits_next = credits - read + release.
  - Simultaneous read and release: net 0.
  - release with credits==CREDITS and read=0: credits stay at CREDITS; set credit_err (sticky until reset).
- Read decision at edge c sets outputs for cycle c+1: read_next = run_next AND credits_next>0.
  - The strobe never asserts with zero credits.
  - Reads may be back-to-back every cycle while credits last.
- Address:
  - On start, the next issued address is sys__wuf__start_addr.
  - After each issued read, the next address is addr+1. MEM_DEPTH-1 wraps to 0.
  - While read=0, wuf__wum__addr holds its last value.
- Transitions:
  - IDLE --start--> RUN, or STALL if credits_next==0.
  - RUN --credits_next==0--> STALL.
  - STALL --credits_next>0--> RUN.
  - RUN/STALL --stop--> IDLE.
  - Start in RUN/STALL restarts: the next read uses the new start_addr, and the count resets to 0.
- Start and stop in the same cycle: start wins; fetch restarts.
- Stop: wuf__wum__read is 0 from the next cycle. Reads already issued still complete in memory, and their credits return normally. Credits are never reloaded except by reset.
- Latency:
  - start at cycle t -> read=1, addr=start_addr in cycle t+1.
  - Data appears at decode in t+3 (memory: 1 input register + 1 output register).
- wuf__sys__count increments on each cycle with read=1; it clears to 0 on start.
- Reset mid-operation: all state clears immediately. Any in-flight memory data is decode's concern; fetch credits reset to CREDITS.

Test Plan:
- Reset, start_addr=0x010 at cycle 5, release pulsed every cycle from cycle 8 -> read high from cycle 6 continuously; addr 0x010,0x011,0x012,...; busy=1.
- CREDITS=4, start_addr=0x020, no releases -> exactly 4 reads (0x020-0x023) in cycles t+1..t+4, then read=0 and busy=1. One release -> one read at 0x024, issued the cycle after release.
- start_addr=0x3FE, releases every cycle -> addr sequence 0x3FE,0x3FF,0x000,0x001; count increments 1,2,3,4.
- Running, stop pulse at cycle s -> read=0 from s+1, busy=0. Later 4 releases return credits without credit_err; a 5th release sets credit_err=1.
- Start and stop in the same cycle while running at 0x050, new start_addr=0x100 -> next read addr=0x100, count=1 after it, busy stays 1.
- Assert reset_poweron asynchronously mid-run between clock edges -> read, addr, count and busy go to 0 immediately; after a new start, 4 reads are issued without any release.
